// File: rtl/ling_lf_subtractor_pipe_if.sv
// Operand/result handshake bundle for the pipelined Ling subtractor.
// The master drives operands and out_ready; the slave answers with results.
interface ling_lf_subtractor_pipe_if #(
  parameter int WIDTH = 12
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             bin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] diff;
  logic             bout;
  logic             ovf;

  modport master (
    output in_valid, a, b, bin, out_ready,
    input  in_ready, out_valid, diff, bout, ovf
  );

  modport slave (
    input  in_valid, a, b, bin, out_ready,
    output in_ready, out_valid, diff, bout, ovf
  );
endinterface

// File: rtl/ling_lf_subtractor_pipe.sv
// Two-stage elastic subtractor: diff = a - b - bin, computed as a + ~b + ~bin
// through a Ling H/I prefix network with Ladner-Fischer (odd-node) sparsity.
module ling_lf_subtractor_pipe #(
  parameter int WIDTH = 12
) (
  input logic                       clk,
  input logic                       rst_n,
  ling_lf_subtractor_pipe_if.slave  bus
);

  // h: Ling pseudo-carry, t: Ling transmit (propagate of the bit below)
  typedef struct packed {
    logic h;
    logic t;
  } lnode_t;

  function automatic lnode_t ling_op(input lnode_t hi, input lnode_t lo);
    lnode_t r;
    r.h = hi.h | (hi.t & lo.h);
    r.t = hi.t & lo.t;
    return r;
  endfunction

  logic in_ready;
  logic s1_load;
  logic s2_load;
  logic out_fire;
  logic s1_valid_reg;
  logic s2_valid_reg;

  logic [WIDTH-1:0] g_in;
  logic [WIDTH-1:0] p_in;
  logic             cin_in;
  lnode_t           lv0 [WIDTH];
  lnode_t           lv1 [WIDTH];
  lnode_t           lv2 [WIDTH];

  logic [WIDTH-1:0] p_reg;
  logic [WIDTH-1:0] g_reg;
  logic             cin_reg;
  logic             a_msb_reg;
  logic             b_msb_reg;
  lnode_t           lv2_reg [WIDTH];

  lnode_t           lv3 [WIDTH];
  lnode_t           lv4 [WIDTH];
  lnode_t           lvf [WIDTH];
  logic [WIDTH-1:0] hf;
  logic [WIDTH:0]   carry;
  logic [WIDTH-1:0] half_sum;
  logic [WIDTH-1:0] diff_next;
  logic             bout_next;
  logic             ovf_next;

  logic [WIDTH-1:0] diff_reg;
  logic             bout_reg;
  logic             ovf_reg;

  // Stage 1 may refill in the same cycle it hands its operand to stage 2.
  assign in_ready = ~s1_valid_reg | ~s2_valid_reg | bus.out_ready;
  assign s1_load  = bus.in_valid & in_ready;
  assign s2_load  = s1_valid_reg & (~s2_valid_reg | bus.out_ready);
  assign out_fire = s2_valid_reg & bus.out_ready;

  assign g_in   = bus.a & ~bus.b;
  assign p_in   = bus.a | ~bus.b;
  assign cin_in = ~bus.bin;

  genvar gi;
  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage1
      // Carry-in folds into bit 0 as an extra generate term.
      if (gi == 0) begin : g_lsb
        assign lv0[gi] = '{h: g_in[0] | cin_in, t: 1'b0};
      end else begin : g_msb
        assign lv0[gi] = '{h: g_in[gi] | g_in[gi-1], t: p_in[gi-1]};
      end

      if ((gi % 2) == 1) begin : g_l1_cell
        assign lv1[gi] = ling_op(lv0[gi], lv0[gi-1]);
      end else begin : g_l1_pass
        assign lv1[gi] = lv0[gi];
      end

      if ((gi % 2) == 1 && ((gi / 2) % 2) == 1) begin : g_l2_cell
        assign lv2[gi] = ling_op(lv1[gi], lv1[(gi / 2) * 2 - 1]);
      end else begin : g_l2_pass
        assign lv2[gi] = lv1[gi];
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_reg     <= '0;
      g_reg     <= '0;
      cin_reg   <= 1'b0;
      a_msb_reg <= 1'b0;
      b_msb_reg <= 1'b0;
      for (int k = 0; k < WIDTH; k++) begin
        lv2_reg[k] <= '0;
      end
    end else if (s1_load) begin
      p_reg     <= p_in;
      g_reg     <= g_in;
      cin_reg   <= cin_in;
      a_msb_reg <= bus.a[WIDTH-1];
      b_msb_reg <= bus.b[WIDTH-1];
      lv2_reg   <= lv2;
    end
  end

  generate
    for (gi = 0; gi < WIDTH; gi++) begin : g_stage2
      if ((gi % 2) == 1 && ((gi / 4) % 2) == 1) begin : g_l3_cell
        assign lv3[gi] = ling_op(lv2_reg[gi], lv2_reg[(gi / 4) * 4 - 1]);
      end else begin : g_l3_pass
        assign lv3[gi] = lv2_reg[gi];
      end

      if ((gi % 2) == 1 && ((gi / 8) % 2) == 1) begin : g_l4_cell
        assign lv4[gi] = ling_op(lv3[gi], lv3[(gi / 8) * 8 - 1]);
      end else begin : g_l4_pass
        assign lv4[gi] = lv3[gi];
      end

      // Even positions pick up their prefix from the completed odd node below.
      if ((gi % 2) == 0 && gi > 0) begin : g_grey_cell
        assign lvf[gi] = ling_op(lv4[gi], lv4[gi-1]);
      end else begin : g_grey_pass
        assign lvf[gi] = lv4[gi];
      end

      assign hf[gi]      = lvf[gi].h;
      assign carry[gi+1] = p_reg[gi] & hf[gi];
    end
  endgenerate

  assign carry[0]  = cin_reg;
  assign half_sum  = p_reg & ~g_reg;
  assign diff_next = half_sum ^ carry[WIDTH-1:0];
  assign bout_next = ~carry[WIDTH];
  assign ovf_next  = (a_msb_reg ^ b_msb_reg) & (diff_next[WIDTH-1] ^ a_msb_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      diff_reg <= '0;
      bout_reg <= 1'b0;
      ovf_reg  <= 1'b0;
    end else if (s2_load) begin
      diff_reg <= diff_next;
      bout_reg <= bout_next;
      ovf_reg  <= ovf_next;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_reg <= 1'b0;
      s2_valid_reg <= 1'b0;
    end else begin
      if (s1_load) begin
        s1_valid_reg <= 1'b1;
      end else if (s2_load) begin
        s1_valid_reg <= 1'b0;
      end

      if (s2_load) begin
        s2_valid_reg <= 1'b1;
      end else if (out_fire) begin
        s2_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = s2_valid_reg;
  assign bus.diff      = diff_reg;
  assign bus.bout      = bout_reg;
  assign bus.ovf       = ovf_reg;

endmodule

// File: tb/tb_ling_lf_subtractor_pipe.sv
// Scoreboard bench for the pipelined Ling subtractor: expected results are
// queued at the input handshake and compared as results leave the block.
module tb_ling_lf_subtractor_pipe;

  logic clk;
  logic rst_n;
  int   errors;
  int   checks;
  int   txn_count;
  logic last_in_fire;
  logic last_out_fire;

  logic [13:0] exp_q[$];
  logic [13:0] obs_q[$];

  ling_lf_subtractor_pipe_if #(.WIDTH(12)) bus ();

  ling_lf_subtractor_pipe #(.WIDTH(12)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [13:0] model(input logic [11:0] a, input logic [11:0] b, input logic bin);
    logic [11:0] d;
    logic        bo;
    logic        ov;
    d  = a - b - {11'b0, bin};
    bo = ({1'b0, a} < ({1'b0, b} + {12'b0, bin}));
    ov = (a[11] != b[11]) && (d[11] != a[11]);
    return {d, bo, ov};
  endfunction

  // Advance one clock; record both handshakes seen just before the edge.
  task automatic tick();
    #1;
    last_in_fire  = bus.in_valid & bus.in_ready;
    last_out_fire = bus.out_valid & bus.out_ready;
    if (last_in_fire) exp_q.push_back(model(bus.a, bus.b, bus.bin));
    if (last_out_fire) begin
      obs_q.push_back({bus.diff, bus.bout, bus.ovf});
      txn_count++;
      $display("txn %0d: diff=%h bout=%b ovf=%b", txn_count, bus.diff, bus.bout, bus.ovf);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [11:0] a, input logic [11:0] b, input logic bin);
    bus.a = a;
    bus.b = b;
    bus.bin = bin;
    bus.in_valid = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.bin = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b want=0", bus.out_valid); end
    checks++;
    if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b want=1", bus.in_ready); end
    checks++;
    if ({bus.diff, bus.bout, bus.ovf} !== 14'h0) begin
      errors++; $display("FAIL reset_outputs got=%h/%b/%b want=000/0/0", bus.diff, bus.bout, bus.ovf);
    end
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL reset_release got valid=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
  endtask

  task automatic test_latency();
    exp_q.delete(); obs_q.delete();
    bus.out_ready = 1'b1;
    drive(12'h000, 12'h001, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL latency_cycle1 got out_valid=%b want=0", bus.out_valid); end
    tick();
    checks++;
    if (bus.out_valid !== 1'b1 || bus.diff !== 12'hFFF || bus.bout !== 1'b1 || bus.ovf !== 1'b0) begin
      errors++;
      $display("FAIL latency_cycle2 got v=%b diff=%h bout=%b ovf=%b want 1/FFF/1/0", bus.out_valid, bus.diff, bus.bout, bus.ovf);
    end
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || obs_q.size() != 1) begin
      errors++; $display("FAIL latency_drain got v=%b count=%0d want 0/1", bus.out_valid, obs_q.size());
    end
  endtask

  task automatic test_directed();
    logic [11:0] ta [5] = '{12'h000, 12'h800, 12'h7FF, 12'h123, 12'hFFF};
    logic [11:0] tb [5] = '{12'h001, 12'h001, 12'hFFF, 12'h123, 12'h000};
    logic        tn [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    logic [13:0] te [5] = '{{12'hFFF, 2'b10}, {12'h7FF, 2'b01}, {12'h800, 2'b11},
                            {12'hFFF, 2'b10}, {12'hFFE, 2'b00}};
    logic [13:0] obs;
    exp_q.delete(); obs_q.delete();
    bus.out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      drive(ta[i], tb[i], tn[i]);
      tick();
    end
    bus.in_valid = 1'b0;
    repeat (3) tick();
    checks++;
    if (obs_q.size() != 5) begin errors++; $display("FAIL directed_count got=%0d want=5", obs_q.size()); end
    for (int i = 0; i < 5; i++) begin
      obs = 'x;
      if (obs_q.size() != 0) obs = obs_q.pop_front();
      checks++;
      if (obs !== te[i]) begin
        errors++;
        $display("FAIL directed_%0d got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b",
                 i, obs[13:2], obs[1], obs[0], te[i][13:2], te[i][1], te[i][0]);
      end
    end
  endtask

  task automatic test_back_pressure();
    logic [11:0] want [3] = '{12'h00F, 12'h01E, 12'h02D};
    logic [13:0] obs;
    int          budget;
    exp_q.delete(); obs_q.delete();
    bus.out_ready = 1'b0;
    drive(12'h010, 12'h001, 1'b0);
    tick();
    drive(12'h020, 12'h002, 1'b0);
    tick();
    drive(12'h030, 12'h003, 1'b0);
    checks++;
    if (bus.in_ready !== 1'b0 || exp_q.size() != 2) begin
      errors++; $display("FAIL bp_full got in_ready=%b captured=%0d want 0/2", bus.in_ready, exp_q.size());
    end
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.out_valid !== 1'b1 || bus.diff !== 12'h00F || bus.in_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_stall_%0d got v=%b diff=%h ready=%b want 1/00F/0", i, bus.out_valid, bus.diff, bus.in_ready);
      end
    end
    bus.out_ready = 1'b1;
    tick();
    bus.in_valid = 1'b0;
    budget = 0;
    while (obs_q.size() < 3 && budget < 10) begin
      tick();
      budget++;
    end
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 3 || bus.out_valid !== 1'b0) begin
      errors++; $display("FAIL bp_count got=%0d v=%b want 3/0", obs_q.size(), bus.out_valid);
    end
    for (int i = 0; i < 3; i++) begin
      obs = 'x;
      if (obs_q.size() != 0) obs = obs_q.pop_front();
      checks++;
      if (obs[13:2] !== want[i] || obs[1:0] !== 2'b00) begin
        errors++; $display("FAIL bp_order_%0d got diff=%h flags=%b want diff=%h flags=00", i, obs[13:2], obs[1:0], want[i]);
      end
    end
  endtask

  task automatic test_throughput();
    int bad_ready;
    int first_seen;
    exp_q.delete(); obs_q.delete();
    bus.out_ready = 1'b1;
    bad_ready = 0;
    first_seen = -1;
    for (int i = 0; i < 1000; i++) begin
      drive(12'($urandom), 12'($urandom), 1'($urandom));
      if (bus.in_ready !== 1'b1) bad_ready++;
      tick();
      if (first_seen < 0 && bus.out_valid === 1'b1) first_seen = i + 1;
    end
    bus.in_valid = 1'b0;
    checks++;
    if (first_seen != 2) begin errors++; $display("FAIL tp_first_result got cycle=%0d want=2", first_seen); end
    checks++;
    if (bad_ready != 0) begin errors++; $display("FAIL tp_in_ready got stalls=%0d want=0", bad_ready); end
    checks++;
    if (obs_q.size() != 998) begin errors++; $display("FAIL tp_rate got=%0d want=998", obs_q.size()); end
    repeat (2) tick();
    checks++;
    if (obs_q.size() != 1000 || exp_q.size() != 1000) begin
      errors++; $display("FAIL tp_count got obs=%0d exp=%0d want 1000", obs_q.size(), exp_q.size());
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      logic [13:0] o;
      logic [13:0] e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL tp_value got diff=%h bout=%b ovf=%b want diff=%h bout=%b ovf=%b", o[13:2], o[1], o[0], e[13:2], e[1], e[0]);
      end
    end
  endtask

  task automatic test_random_ready();
    int          sent;
    int          cycles;
    logic        pv;
    logic        pr;
    logic [13:0] pd;
    exp_q.delete(); obs_q.delete();
    sent = 0;
    cycles = 0;
    bus.in_valid = 1'b0;
    while ((sent < 500 || obs_q.size() < 500) && cycles < 5000) begin
      if (!bus.in_valid && sent < 500 && $urandom_range(0, 3) != 0)
        drive(12'($urandom), 12'($urandom), 1'($urandom));
      bus.out_ready = ($urandom_range(0, 1) == 1);
      pv = bus.out_valid;
      pr = bus.out_ready;
      pd = {bus.diff, bus.bout, bus.ovf};
      tick();
      cycles++;
      if (last_in_fire) begin
        sent++;
        bus.in_valid = 1'b0;
      end
      if (pv && !pr) begin
        checks++;
        if (bus.out_valid !== 1'b1 || {bus.diff, bus.bout, bus.ovf} !== pd) begin
          errors++; $display("FAIL rr_hold got v=%b data=%h want 1/%h", bus.out_valid, {bus.diff, bus.bout, bus.ovf}, pd);
        end
      end
    end
    checks++;
    if (cycles >= 5000 || obs_q.size() != 500 || exp_q.size() != 500) begin
      errors++; $display("FAIL rr_count got obs=%0d exp=%0d cycles=%0d want 500/500", obs_q.size(), exp_q.size(), cycles);
    end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      logic [13:0] o;
      logic [13:0] e;
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++;
      if (o !== e) begin
        errors++; $display("FAIL rr_value got=%h want=%h", o, e);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [13:0] obs;
    bus.out_ready = 1'b0;
    drive(12'h0AA, 12'h011, 1'b0);
    tick();
    drive(12'h0BB, 12'h022, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    checks++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0) begin
      errors++; $display("FAIL rm_full got v=%b ready=%b want 1/0", bus.out_valid, bus.in_ready);
    end
    rst_n = 1'b0;
    #2;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rm_async got v=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    exp_q.delete(); obs_q.delete();
    bus.out_ready = 1'b1;
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++; $display("FAIL rm_release got v=%b ready=%b want 0/1", bus.out_valid, bus.in_ready);
    end
    drive(12'h005, 12'h003, 1'b0);
    tick();
    bus.in_valid = 1'b0;
    repeat (5) tick();
    checks++;
    if (obs_q.size() != 1) begin errors++; $display("FAIL rm_count got=%0d want=1", obs_q.size()); end
    obs = 'x;
    if (obs_q.size() != 0) obs = obs_q.pop_front();
    checks++;
    if (obs !== {12'h002, 2'b00}) begin
      errors++; $display("FAIL rm_value got diff=%h flags=%b want diff=002 flags=00", obs[13:2], obs[1:0]);
    end
  endtask

  initial begin
    errors = 0;
    checks = 0;
    txn_count = 0;
    last_in_fire = 1'b0;
    last_out_fire = 1'b0;
    test_reset();
    test_latency();
    test_directed();
    test_back_pressure();
    test_throughput();
    test_random_ready();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
